shift_seq_ctrl: RTL and testbench

//  Sequencer that drives a 1-bit right-shift stage to realise a variable

---
 rtl/shift_seq_ctrl.sv | 119 +++++++++++
 tb/tb_shift_seq_ctrl.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/shift_seq_ctrl.sv
// rtl/shift_seq_ctrl.sv - bit-serial arithmetic right-shift sequencer for CORDIC X/Y operands
//
// Replaces a barrel shifter with one 1-bit arithmetic shift stage per operand,
// applied once per clock until the requested distance has been covered.
//
// Ports:
//   clk        rising-edge clock
//   reset_b    asynchronous active-low reset
//   in_valid   request valid (held by upstream until accepted)
//   in_ready   sequencer idle and able to accept a request
//   x_in/y_in  two's-complement operands
//   sh_amt     requested right-shift distance (clamped to WIDTH-1)
//   out_valid  result valid, held until out_ready
//   out_ready  consumer accepts the result
//   x_out/y_out  shifted operands (intermediate values while shifting)
//   busy       sequencer is in any state other than IDLE
module shift_seq_ctrl #(
    parameter int WIDTH = 16,
    parameter int SHW   = 4
) (
    input  logic             clk,
    input  logic             reset_b,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x_in,
    input  logic [WIDTH-1:0] y_in,
    input  logic [SHW-1:0]   sh_amt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] x_out,
    output logic [WIDTH-1:0] y_out,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [SHW-1:0] MAX_SH = SHW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [SHW-1:0]   count_q, count_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;
    logic [SHW-1:0]   eff;

    // Distances beyond WIDTH-1 already give an all-sign-bit result.
    assign eff = (sh_amt > MAX_SH) ? MAX_SH : sh_amt;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        x_d     = x_q;
        y_d     = y_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    x_d     = x_in;
                    y_d     = y_in;
                    count_d = eff;
                    state_d = (eff == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                // One arithmetic bit per clock: the MSB is replicated.
                x_d     = {x_q[WIDTH-1], x_q[WIDTH-1:1]};
                y_d     = {y_q[WIDTH-1], y_q[WIDTH-1:1]};
                count_d = count_q - SHW'(1);
                if (count_q == SHW'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Handshake outputs are registered copies of the next-state decode.
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q     <= IDLE;
            count_q     <= '0;
            x_q         <= '0;
            y_q         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            x_q         <= x_d;
            y_q         <= y_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign x_out     = x_q;
    assign y_out     = y_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb/tb_shift_seq_ctrl.sv - directed self-checking bench for shift_seq_ctrl
module tb_shift_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset_b = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] x_in = '0;
    logic [15:0] y_in = '0;
    logic [3:0]  sh_amt = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] x_out;
    logic [15:0] y_out;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    shift_seq_ctrl #(.WIDTH(16), .SHW(4)) dut (
        .clk       (clk),
        .reset_b   (reset_b),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_in      (x_in),
        .y_in      (y_in),
        .sh_amt    (sh_amt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .x_out     (x_out),
        .y_out     (y_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request, take the accept edge, then count edges to out_valid.
    task automatic accept(input logic [15:0] x, input logic [15:0] y, input logic [3:0] sh);
        chk("pre_in_ready", in_ready, 1);
        x_in = x; y_in = y; sh_amt = sh; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int exp_lat);
        int lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        chk({tag, "_lat"}, lat, exp_lat);
    endtask

    task automatic txn(input string tag, input logic [15:0] x, input logic [15:0] y,
                       input logic [3:0] sh, input logic [15:0] ex, input logic [15:0] ey,
                       input int exp_lat);
        accept(x, y, sh);
        wait_done(tag, exp_lat);
        chk({tag, "_x"}, x_out, ex);
        chk({tag, "_y"}, y_out, ey);
        chk({tag, "_inrdy_done"}, in_ready, 0);
        tick();
        chk({tag, "_idle_inrdy"}, in_ready, 1);
        chk({tag, "_idle_ovld"}, out_valid, 0);
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_x", x_out, 0);
        reset_b = 1'b1;
        tick();
        tick();

        // Reset asserted mid-SHIFT takes effect without a clock edge
        accept(16'h1234, 16'h5678, 4'd10);
        tick();
        tick();
        chk("mid_busy", busy, 1);
        #2 reset_b = 1'b0;
        #1;
        chk("arst_in_ready", in_ready, 1);
        chk("arst_out_valid", out_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_x", x_out, 0);
        chk("arst_y", y_out, 0);
        tick();
        reset_b = 1'b1;
        tick();
        chk("post_rst_ovld", out_valid, 0);

        // Zero shift, sign fill, max shift, positive data
        txn("zero", 16'h1234, 16'hF00F, 4'd0, 16'h1234, 16'hF00F, 0);
        txn("sign3", 16'h8000, 16'h4000, 4'd3, 16'hF000, 16'h0800, 3);
        txn("max15", 16'h7FFF, 16'h8001, 4'd15, 16'h0000, 16'hFFFF, 15);
        txn("sh7", 16'h4C00, 16'hB400, 4'd7, 16'h0098, 16'hFF68, 7);

        // Backpressure: result and handshake held while out_ready is low
        out_ready = 1'b0;
        accept(16'hA5A5, 16'h0F0F, 4'd1);
        wait_done("bp", 1);
        for (int i = 0; i < 5; i++) begin
            chk("bp_ovld", out_valid, 1);
            chk("bp_x", x_out, 16'hD2D2);
            chk("bp_y", y_out, 16'h0787);
            chk("bp_inrdy", in_ready, 0);
            tick();
        end
        out_ready = 1'b1;
        chk("bp_last_ovld", out_valid, 1);
        tick();
        chk("bp_rel_inrdy", in_ready, 1);
        chk("bp_rel_ovld", out_valid, 0);
        chk("bp_rel_busy", busy, 0);

        // Inputs and in_valid ignored while busy
        accept(16'h0100, 16'hFF00, 4'd4);
        x_in = 16'hFFFF; y_in = 16'h0001; sh_amt = 4'd1;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("ign_busy", busy, 1);
        wait_done("ign", 3);
        chk("ign_x", x_out, 16'h0010);
        chk("ign_y", y_out, 16'hFFF0);
        tick();
        chk("ign_idle", in_ready, 1);
        for (int i = 0; i < 4; i++) begin
            chk("ign_no_extra", {out_valid, busy}, 2'b00);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
